// File: rtl/lt_bank_sync.sv
// Clock-domain replacement for a bank of nG-gated transparent latch cells.
// Every channel runs its own HELD/ARMING/OPEN machine sampled on CLK, with an optional gate debounce.
module lt_bank_sync #(
  parameter int                 WIDTH    = 4,
  parameter int                 CHANNELS = 2,
  parameter int                 BYPASS   = 1,
  parameter int                 FILTER   = 0,
  parameter logic [WIDTH-1:0]   INIT     = '0
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [CHANNELS-1:0]          nG,
  input  logic [CHANNELS*WIDTH-1:0]    D,
  output logic [CHANNELS*WIDTH-1:0]    P,
  output logic [CHANNELS*WIDTH-1:0]    N,
  output logic [CHANNELS-1:0]          CLOSE_STB
);

  localparam int CNT_W = (FILTER < 1) ? 1 : $clog2(FILTER + 1);
  localparam logic [CNT_W-1:0] FILT    = CNT_W'(FILTER);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    HELD   = 2'd0,
    ARMING = 2'd1,
    OPEN   = 2'd2
  } state_t;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               stb_q, stb_d;
    logic [WIDTH-1:0]   d_ch;

    assign d_ch = D[c*WIDTH +: WIDTH];

    // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      stb_d   = 1'b0;
      unique case (state_q)
        HELD: begin
          if (!nG[c]) begin
            if (FILTER == 0) begin
              state_d = OPEN;
              hold_d  = d_ch;
            end else begin
              state_d = ARMING;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ARMING: begin
          if (nG[c]) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == FILT) begin
            state_d = OPEN;
            hold_d  = d_ch;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        OPEN: begin
          // Closing is never debounced; the value from the last low sample stays held.
          if (!nG[c]) begin
            hold_d = d_ch;
          end else begin
            state_d = HELD;
            stb_d   = 1'b1;
          end
        end
        default: state_d = HELD;
      endcase
    end

    // NOTE: state registers use non-blocking assignments so all channels update from pre-edge values.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        state_q <= HELD;
        cnt_q   <= '0;
        hold_q  <= INIT;
        stb_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hold_q  <= hold_d;
        stb_q   <= stb_d;
      end
    end

    assign P[c*WIDTH +: WIDTH] = ((BYPASS != 0) && (state_q == OPEN)) ? d_ch : hold_q;
    assign CLOSE_STB[c]        = stb_q;
  end

  assign N = ~P;

endmodule

// File: tb/tb_lt_bank_sync.sv
// Bench for lt_bank_sync: four DUT configurations (BYPASS x FILTER) share one stimulus stream
// and are checked every cycle against a run-length model of a cycle-sampled latch.
module tb_lt_bank_sync;
  localparam int W    = 4;
  localparam int C    = 2;
  localparam int NDUT = 4;
  localparam logic [W-1:0] INIT_V = 4'hA;

  logic           clk = 1'b0;
  logic           rst;
  logic [C-1:0]   ng;
  logic [C*W-1:0] d;
  logic [C*W-1:0] p_out   [NDUT];
  logic [C*W-1:0] n_out   [NDUT];
  logic [C-1:0]   stb_out [NDUT];

  always #5 clk = ~clk;

  lt_bank_sync #(.WIDTH(W), .CHANNELS(C), .BYPASS(0), .FILTER(0), .INIT(INIT_V)) u0 (
    .CLK(clk), .RESET(rst), .nG(ng), .D(d), .P(p_out[0]), .N(n_out[0]), .CLOSE_STB(stb_out[0]));
  lt_bank_sync #(.WIDTH(W), .CHANNELS(C), .BYPASS(1), .FILTER(0), .INIT(INIT_V)) u1 (
    .CLK(clk), .RESET(rst), .nG(ng), .D(d), .P(p_out[1]), .N(n_out[1]), .CLOSE_STB(stb_out[1]));
  lt_bank_sync #(.WIDTH(W), .CHANNELS(C), .BYPASS(0), .FILTER(2), .INIT(INIT_V)) u2 (
    .CLK(clk), .RESET(rst), .nG(ng), .D(d), .P(p_out[2]), .N(n_out[2]), .CLOSE_STB(stb_out[2]));
  lt_bank_sync #(.WIDTH(W), .CHANNELS(C), .BYPASS(1), .FILTER(2), .INIT(INIT_V)) u3 (
    .CLK(clk), .RESET(rst), .nG(ng), .D(d), .P(p_out[3]), .N(n_out[3]), .CLOSE_STB(stb_out[3]));

  // Model: a channel is open once nG has been sampled low on FILTER+1 consecutive edges.
  int           byp_m  [NDUT];
  int           flt_m  [NDUT];
  int           run_m  [NDUT][C];
  logic [W-1:0] hold_m [NDUT][C];
  logic         stb_m  [NDUT][C];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] exp_p(input int k, input int c);
    if (byp_m[k] != 0 && run_m[k][c] >= flt_m[k] + 1) return d[c*W +: W];
    return hold_m[k][c];
  endfunction

  task automatic model_step();
    for (int k = 0; k < NDUT; k++) begin
      for (int c = 0; c < C; c++) begin
        if (rst) begin
          run_m[k][c]  = 0;
          hold_m[k][c] = INIT_V;
          stb_m[k][c]  = 1'b0;
        end else begin
          bit was_open, now_open;
          was_open = run_m[k][c] >= flt_m[k] + 1;
          if (!ng[c]) begin
            if (run_m[k][c] < 1000) run_m[k][c]++;
          end else begin
            run_m[k][c] = 0;
          end
          now_open = run_m[k][c] >= flt_m[k] + 1;
          if (now_open) hold_m[k][c] = d[c*W +: W];
          stb_m[k][c] = was_open && !now_open;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NDUT; k++) begin
      for (int c = 0; c < C; c++) begin
        logic [W-1:0] ep, en;
        ep = exp_p(k, c);
        en = ~ep;
        check($sformatf("u%0d.P%0d", k, c), p_out[k][c*W +: W], ep);
        check($sformatf("u%0d.N%0d", k, c), n_out[k][c*W +: W], en);
        check($sformatf("u%0d.STB%0d", k, c), stb_out[k][c], stb_m[k][c]);
      end
    end
  endtask

  // Inputs change at the falling edge; the model advances at the rising edge; outputs compared at the next fall.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    byp_m = '{0, 1, 0, 1};
    flt_m = '{0, 0, 2, 2};
    rst = 1'b1;
    ng  = 2'b11;
    d   = 8'h00;

    // Reset held for two cycles
    tick();
    tick();
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst u%0d P", k), p_out[k], 8'hAA);
      check($sformatf("rst u%0d N", k), n_out[k], 8'h55);
      check($sformatf("rst u%0d STB", k), stb_out[k], 2'b00);
    end
    rst = 1'b0;

    // Registered open/close on u0 (ch1 data present but gate closed)
    ng = 2'b10; d = 8'h51; tick(); check("oc P0 #1", p_out[0][3:0], 4'h1);
    d = 8'h52;             tick(); check("oc P0 #2", p_out[0][3:0], 4'h2);
    d = 8'h53;             tick(); check("oc P0 #3", p_out[0][3:0], 4'h3);
    ng = 2'b11; d = 8'h5F; tick(); check("oc P0 #4", p_out[0][3:0], 4'h3);
    check("oc STB0 pulse", stb_out[0][0], 1'b1);
    tick();
    check("oc P0 #5", p_out[0][3:0], 4'h3);
    check("oc STB0 low", stb_out[0][0], 1'b0);
    check("oc P1 idle", p_out[0][7:4], 4'hA);

    // Bypass on u1
    ng = 2'b10; d = 8'h57; #1;
    check("byp held", p_out[1][3:0], 4'h3);
    tick();
    check("byp open", p_out[1][3:0], 4'h7);
    d = 8'h59; #1;
    check("byp follow", p_out[1][3:0], 4'h9);
    tick();
    ng = 2'b11; tick();
    check("byp hold", p_out[1][3:0], 4'h9);
    check("byp STB0", stb_out[1][0], 1'b1);

    // Debounce on u2 (FILTER=2)
    rst = 1'b1; tick(); rst = 1'b0;
    ng = 2'b10; d = 8'h51; tick();
    d = 8'h52;             tick();
    ng = 2'b11; d = 8'h5F; tick();
    check("flt glitch P0", p_out[2][3:0], 4'hA);
    check("flt glitch STB", stb_out[2][0], 1'b0);
    ng = 2'b10; d = 8'h51; tick(); check("flt low1", p_out[2][3:0], 4'hA);
    d = 8'h52;             tick(); check("flt low2", p_out[2][3:0], 4'hA);
    d = 8'h53;             tick(); check("flt low3", p_out[2][3:0], 4'h3);
    d = 8'h54;             tick(); check("flt low4", p_out[2][3:0], 4'h4);

    // Reset while u2 ch0 is OPEN and ch1 is ARMING, with ch0 also trying to close
    ng = 2'b00; d = 8'h64; tick();
    rst = 1'b1; ng = 2'b11; tick();
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("midrst u%0d P", k), p_out[k], 8'hAA);
      check($sformatf("midrst u%0d STB", k), stb_out[k], 2'b00);
    end
    rst = 1'b0; tick();
    check("midrst STB after", stb_out[2], 2'b00);

    // Gate toggling every cycle never opens a filtered channel
    for (int i = 0; i < 12; i++) begin
      ng = (i % 2 == 0) ? 2'b10 : 2'b11;
      d  = 8'(8'h30 + i);
      tick();
      check("toggle P0", p_out[2][3:0], 4'hA);
      check("toggle STB0", stb_out[2][0], 1'b0);
    end

    // Random traffic with occasional resets
    for (int i = 0; i < 10000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      ng  = C'($urandom);
      d   = (C*W)'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
